// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: flow controller for an NUM_STAGES-deep LC-3b pipeline.
// It turns per-stage stall and flush requests into latch load enables,
// NOP-inject selects and PC strobes. It also tracks a registered valid bit
// per inter-stage latch, and keeps a flush that arrives while its stage is
// held until that stage is free.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall and flush counters.
//
// Handshake: a latch advances only when load_en[i]=1. A stage that raises
// stall_req keeps its own contents and freezes every younger stage. The
// first older latch boundary then receives a bubble. Flushes are applied
// when the requesting stage is not held. Otherwise they are remembered
// and applied on the first cycle that stage can move.
module pipe_flow_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-2:0] load_en,
  output logic [NUM_STAGES-2:0] bubble,
  output logic                  pc_load,
  output logic                  pc_redirect,
  output logic                  flush_ack,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic [NUM_STAGES-2:0] valid
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  pend_valid;
  logic [SW-1:0]         pend_stage;

  logic [NUM_STAGES-1:0] req_vec;
  logic [NUM_STAGES-1:0] hold_raw;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] younger_mask;
  logic [NUM_STAGES-1:0] stall_m;
  logic                  eff_found;
  logic [SW-1:0]         eff_stage;
  logic                  flush_apply;
  logic                  flush_defer;
  logic [NUM_STAGES-2:0] valid_prev;

  // Pick the oldest flush source, and derive hold chains, enables, bubbles and PC strobes.
  always_comb begin
    req_vec      = flush_req & ~NUM_STAGES'(1);
    hold_raw     = '0;
    hold         = '0;
    younger_mask = '0;
    eff_found    = 1'b0;
    eff_stage    = '0;
    load_en      = '1;
    bubble       = '0;
    pc_load      = 1'b0;
    pc_redirect  = 1'b0;
    flush_ack    = 1'b0;

    if (pend_valid) req_vec[pend_stage] = 1'b1;

    hold_raw[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
    for (int k = NUM_STAGES-2; k >= 0; k--) hold_raw[k] = hold_raw[k+1] | stall_req[k];

    // Ascending scan: the last hit is the oldest requester.
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (req_vec[k]) begin
        eff_found = 1'b1;
        eff_stage = SW'(k);
      end
    end

    flush_apply = eff_found && !hold_raw[eff_stage];
    flush_defer = eff_found &&  hold_raw[eff_stage];

    for (int k = 0; k < NUM_STAGES; k++) younger_mask[k] = flush_apply && (SW'(k) < eff_stage);

    // Stages being squashed cannot hold the pipe back.
    stall_m = stall_req & ~younger_mask;
    hold[NUM_STAGES-1] = stall_m[NUM_STAGES-1];
    for (int k = NUM_STAGES-2; k >= 0; k--) hold[k] = hold[k+1] | stall_m[k];

    for (int i = 0; i < NUM_STAGES-1; i++) begin
      load_en[i] = !hold[i+1];
      bubble[i]  = hold[i] && !hold[i+1];
    end
    bubble = bubble | younger_mask[NUM_STAGES-2:0];

    pc_load     = !hold[0] || flush_apply;
    pc_redirect = flush_apply;
    flush_ack   = flush_apply;

    if (reset) begin
      load_en     = '1;
      bubble      = '1;
      pc_load     = 1'b0;
      pc_redirect = 1'b0;
      flush_ack   = 1'b0;
      flush_apply = 1'b0;
      flush_defer = 1'b0;
    end
  end

  assign valid_prev = {valid[NUM_STAGES-3:0], fetch_valid};

  // Valid bits follow the data through each latch; the pending flush is kept until it can apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      pend_valid <= 1'b0;
      pend_stage <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES-1; i++)
        if (load_en[i]) valid[i] <= bubble[i] ? 1'b0 : valid_prev[i];
      if (flush_apply) begin
        pend_valid <= 1'b0;
      end else if (flush_defer) begin
        pend_valid <= 1'b1;
        pend_stage <= eff_stage;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counters of lost fetch cycles and applied flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_load && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ack && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl with NUM_STAGES=5.
// Define PIPE_PERF_CNT_EN to also exercise the counters, which use CNT_W=3.
module tb_pipe_flow_ctrl;

  localparam int N     = 5;
  localparam int CNT_W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic [N-1:0] stall_req;
  logic [N-1:0] flush_req;
  logic [N-2:0] load_en;
  logic [N-2:0] bubble;
  logic         pc_load;
  logic         pc_redirect;
  logic         flush_ack;
  logic [N-2:0] valid;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_flow_ctrl #(.NUM_STAGES(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .load_en     (load_en),
    .bubble      (bubble),
    .pc_load     (pc_load),
    .pc_redirect (pc_redirect),
    .flush_ack   (flush_ack),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .valid       (valid)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Advance one edge and sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet inputs and fill the pipeline with real instructions.
  task automatic fill();
    stall_req   = '0;
    flush_req   = '0;
    fetch_valid = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_valid = 1'b1; stall_req = 5'b11111; flush_req = 5'b11110;
    #2;
    checks++; if (load_en !== 4'b1111) begin failures++; $display("FAIL rst_load_en got=%b exp=1111", load_en); end
    checks++; if (bubble !== 4'b1111) begin failures++; $display("FAIL rst_bubble got=%b exp=1111", bubble); end
    checks++; if ({pc_load, pc_redirect, flush_ack} !== 3'b000) begin failures++; $display("FAIL rst_pc got=%b exp=000", {pc_load, pc_redirect, flush_ack}); end
    tick(); tick();
    checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL rst_valid got=%b exp=0000", valid); end
    reset = 1'b0; stall_req = '0; flush_req = '0;
    #1;
    checks++; if (pc_load !== 1'b1) begin failures++; $display("FAIL rel_pc_load got=%b exp=1", pc_load); end
    checks++; if (bubble !== 4'b0000) begin failures++; $display("FAIL rel_bubble got=%b exp=0000", bubble); end
    tick();
    checks++; if (valid !== 4'b0001) begin failures++; $display("FAIL fill_1 got=%b exp=0001", valid); end
    tick();
    checks++; if (valid !== 4'b0011) begin failures++; $display("FAIL fill_2 got=%b exp=0011", valid); end
    tick();
    checks++; if (valid !== 4'b0111) begin failures++; $display("FAIL fill_3 got=%b exp=0111", valid); end
    tick();
    checks++; if (valid !== 4'b1111) begin failures++; $display("FAIL fill_4 got=%b exp=1111", valid); end
  endtask

  task automatic test_stall();
    fill();
    stall_req = 5'b01000;
    #1;
    checks++; if (load_en !== 4'b1000) begin failures++; $display("FAIL stall_load_en got=%b exp=1000", load_en); end
    checks++; if (bubble !== 4'b1000) begin failures++; $display("FAIL stall_bubble got=%b exp=1000", bubble); end
    checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL stall_pc_load got=%b exp=0", pc_load); end
    tick();
    checks++; if (valid !== 4'b0111) begin failures++; $display("FAIL stall_valid_1 got=%b exp=0111", valid); end
    tick(); tick();
    checks++; if (valid !== 4'b0111) begin failures++; $display("FAIL stall_valid_3 got=%b exp=0111", valid); end
    stall_req = '0;
    #1;
    checks++; if (load_en !== 4'b1111) begin failures++; $display("FAIL unstall_load_en got=%b exp=1111", load_en); end
    checks++; if (bubble !== 4'b0000) begin failures++; $display("FAIL unstall_bubble got=%b exp=0000", bubble); end
    tick();
    checks++; if (valid !== 4'b1111) begin failures++; $display("FAIL unstall_valid got=%b exp=1111", valid); end
  endtask

  task automatic test_flush();
    fill();
    flush_req = 5'b00100;
    #1;
    checks++; if (bubble !== 4'b0011) begin failures++; $display("FAIL flush_bubble got=%b exp=0011", bubble); end
    checks++; if (load_en !== 4'b1111) begin failures++; $display("FAIL flush_load_en got=%b exp=1111", load_en); end
    checks++; if ({pc_load, pc_redirect, flush_ack} !== 3'b111) begin failures++; $display("FAIL flush_pc got=%b exp=111", {pc_load, pc_redirect, flush_ack}); end
    tick();
    flush_req = '0;
    checks++; if (valid !== 4'b1100) begin failures++; $display("FAIL flush_valid got=%b exp=1100", valid); end
  endtask

  task automatic test_deferred_flush();
    int pulses;
    fill();
    pulses = 0;
    flush_req = 5'b00100; stall_req = 5'b10000;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (flush_ack === 1'b1) pulses++;
      checks++; if (load_en !== 4'b0000) begin failures++; $display("FAIL defer_load_en cyc=%0d got=%b exp=0000", c, load_en); end
      tick();
      flush_req = '0;
    end
    stall_req = '0;
    #1;
    if (flush_ack === 1'b1) pulses++;
    checks++; if (bubble !== 4'b0011) begin failures++; $display("FAIL defer_bubble got=%b exp=0011", bubble); end
    checks++; if (pc_redirect !== 1'b1) begin failures++; $display("FAIL defer_redirect got=%b exp=1", pc_redirect); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      if (flush_ack === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL defer_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_dual_flush();
    fill();
    flush_req = 5'b01010;
    #1;
    checks++; if (bubble !== 4'b0111) begin failures++; $display("FAIL dual_bubble got=%b exp=0111", bubble); end
    checks++; if (flush_ack !== 1'b1) begin failures++; $display("FAIL dual_ack got=%b exp=1", flush_ack); end
    tick();
    flush_req = '0;
    checks++; if (valid !== 4'b1000) begin failures++; $display("FAIL dual_valid got=%b exp=1000", valid); end
    #1;
    checks++; if ({bubble, flush_ack, pc_redirect} !== 6'b000000) begin failures++; $display("FAIL dual_late got=%b exp=000000", {bubble, flush_ack, pc_redirect}); end
  endtask

  task automatic test_reset_pending();
    fill();
    stall_req = 5'b10000; flush_req = 5'b00100;
    tick();
    flush_req = '0; reset = 1'b1;
    tick();
    reset = 1'b0; stall_req = '0;
    #1;
    checks++; if ({flush_ack, pc_redirect} !== 2'b00) begin failures++; $display("FAIL rstpend_ack got=%b exp=00", {flush_ack, pc_redirect}); end
    checks++; if (bubble !== 4'b0000) begin failures++; $display("FAIL rstpend_bubble got=%b exp=0000", bubble); end
    checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL rstpend_valid got=%b exp=0000", valid); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_counters();
    stall_req = '0; flush_req = '0; reset = 1'b1;
    tick();
    checks++; if ({stall_cnt, flush_cnt} !== 6'd0) begin failures++; $display("FAIL cnt_rst got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    reset = 1'b0; stall_req = 5'b00001;
    repeat (9) tick();
    stall_req = '0;
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL cnt_stall got=%0d exp=7", stall_cnt); end
    flush_req = 5'b00100; tick();
    flush_req = '0;       tick();
    flush_req = 5'b01000; tick();
    flush_req = '0;       tick();
    checks++; if (flush_cnt !== 3'd2) begin failures++; $display("FAIL cnt_flush got=%0d exp=2", flush_cnt); end
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++; if ({stall_cnt, flush_cnt} !== 6'd0) begin failures++; $display("FAIL cnt_rst2 got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; stall_req = '0; flush_req = '0;
    test_reset();
    test_stall();
    test_flush();
    test_deferred_flush();
    test_dual_flush();
    test_reset_pending();
`ifdef PIPE_PERF_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
